// File: rtl/mips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_pkg: shared types for the memory-port arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int MEM_WORD_W = 32;
  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUS  = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

  // Operands of the transaction currently owning the bus; word address only.
  typedef struct packed {
    req_id_t                   id;
    logic                      we;
    logic [MEM_WORD_W-1:2]     addr;
    logic [MEM_WORD_W-1:0]     wdata;
    logic [3:0]                be;
  } mem_op_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_select.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_select: data-first winner pick with a bounded data streak.  Rev 1.0
// ---------------------------------------------------------------------------
module mem_arb_select
  import mips_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    arb_en,
  input  logic    if_req,
  input  logic    d_req,
  output logic    grant_valid,
  output req_id_t grant_id
);

  localparam int STREAK_W = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak;
  logic                fetch_turn;

  always_comb begin
    fetch_turn  = if_req && (streak == STREAK_MAX);
    grant_valid = arb_en && (if_req || d_req);
    grant_id    = (d_req && !fetch_turn) ? REQ_DATA : REQ_FETCH;
  end

  // The streak only measures how long a waiting fetch has been passed over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (!if_req) begin
      streak <= '0;
    end else if (grant_valid) begin
      if (grant_id == REQ_FETCH) begin
        streak <= '0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + STREAK_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter: shares one waitrequest word bus between fetch and data.  Rev 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [MEM_WORD_W-1:0] if_addr,
  output logic                  if_ack,
  output logic [MEM_WORD_W-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [MEM_WORD_W-1:0] d_addr,
  input  logic [MEM_WORD_W-1:0] d_wdata,
  input  logic [3:0]            d_byteen,
  output logic                  d_ack,
  output logic [MEM_WORD_W-1:0] d_rdata,
  output logic [MEM_WORD_W-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_WORD_W-1:0] mem_writedata,
  output logic [3:0]            mem_byteenable,
  input  logic                  mem_waitrequest,
  input  logic [MEM_WORD_W-1:0] mem_readdata,
  output logic                  stall,
  output logic                  bus_error
);

  localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  arb_state_t          state;
  arb_state_t          next_state;
  mem_op_t             op;
  mem_op_t             next_op;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                timed_out;
  logic                grant_valid;
  req_id_t             grant_id;
  logic                load_op;
  logic                capture;
  logic                abort;
  logic                in_bus;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  mem_arb_select #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_select (
    .clk         (clk),
    .rst_n       (rst_n),
    .arb_en      (state == ARB_IDLE),
    .if_req      (if_req),
    .d_req       (d_req),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    if (grant_id == REQ_DATA) begin
      next_op = '{id: REQ_DATA, we: d_we, addr: d_addr[MEM_WORD_W-1:2],
                  wdata: d_wdata, be: d_byteen};
    end else begin
      next_op = '{id: REQ_FETCH, we: 1'b0, addr: if_addr[MEM_WORD_W-1:2],
                  wdata: {MEM_WORD_W{1'b0}}, be: BE_ALL};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_op    = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (grant_valid) begin
          load_op    = 1'b1;
          next_state = ARB_BUS;
        end
      end
      ARB_BUS: begin
        if (!mem_waitrequest) begin
          capture    = 1'b1;
          next_state = ARB_DONE;
        end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
          abort      = 1'b1;
          next_state = ARB_DONE;
        end
      end
      ARB_DONE: next_state = ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  // Strobes and acks decode straight from state so reset kills them at once.
  always_comb begin
    in_bus         = (state == ARB_BUS);
    mem_read       = in_bus && !op.we;
    mem_write      = in_bus && op.we;
    mem_address    = {op.addr, 2'b00};
    mem_writedata  = op.wdata;
    mem_byteenable = op.be;
    if_ack         = (state == ARB_DONE) && (op.id == REQ_FETCH);
    d_ack          = (state == ARB_DONE) && (op.id == REQ_DATA);
    bus_error      = (state == ARB_DONE) && timed_out;
    stall          = (if_req && !if_ack) || (d_req && !d_ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op        <= '0;
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      if (load_op) begin
        op        <= next_op;
        wait_cnt  <= '0;
        timed_out <= 1'b0;
      end else if (in_bus && mem_waitrequest) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (abort) begin
        timed_out <= 1'b1;
      end
    end
  end

  // A timed-out read returns zero; writes never touch the read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if ((capture || abort) && !op.we) begin
      if (op.id == REQ_FETCH) begin
        if_rdata <= capture ? mem_readdata : '0;
      end else begin
        d_rdata  <= capture ? mem_readdata : '0;
      end
    end
  end

endmodule
`default_nettype wire
